// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter slice.
package arb_pkg;

    localparam int unsigned NREQ = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/onehot_dec2x4.sv
// 2-to-4 one-hot decoder with a gating enable on every output.
module onehot_dec2x4 (
    input  logic [1:0] sel,
    input  logic       en,
    output logic [3:0] y
);

    assign y[0] = en & ~sel[1] & ~sel[0];
    assign y[1] = en & ~sel[1] &  sel[0];
    assign y[2] = en &  sel[1] & ~sel[0];
    assign y[3] = en &  sel[1] &  sel[0];

endmodule

// File: rtl/arb4_rr_ctrl.sv
// Four-requester round-robin arbiter with a per-grant hold limit.
module arb4_rr_ctrl
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       expired
);

    localparam int unsigned CW = $clog2(MAX_HOLD);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 1);

    state_t        state, state_d;
    logic [1:0]    ptr, ptr_d;
    logic [1:0]    id_d;
    logic [CW-1:0] hold_cnt, cnt_d;
    logic          exp_d;

    // First asserted request scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = p;
        found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = p + 2'(k);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // State and datapath registers; reset drops any grant immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            gnt_id   <= '0;
            hold_cnt <= '0;
            expired  <= 1'b0;
        end else begin
            state    <= state_d;
            ptr      <= ptr_d;
            gnt_id   <= id_d;
            hold_cnt <= cnt_d;
            expired  <= exp_d;
        end
    end

    // Next-state: pick in IDLE, then hold until drop (wins) or hold limit.
    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        id_d    = gnt_id;
        cnt_d   = hold_cnt;
        exp_d   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    id_d    = rr_pick(req, ptr);
                    cnt_d   = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!req[gnt_id]) begin
                    state_d = ST_IDLE;
                    ptr_d   = gnt_id + 2'd1;
                end else if (hold_cnt == CNT_LAST) begin
                    state_d = ST_IDLE;
                    ptr_d   = gnt_id + 2'd1;
                    exp_d   = 1'b1;
                end else begin
                    cnt_d = hold_cnt + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign gnt_valid = (state == ST_GRANT);

    onehot_dec2x4 u_dec (
        .sel (gnt_id),
        .en  (gnt_valid),
        .y   (gnt)
    );

endmodule

// File: doc/arb4_rr_ctrl.md
# arb4_rr_ctrl

Four-requester round-robin arbiter that shares one resource among four clients. It drives that resource's select lines through the 2-to-4 one-hot decoder used elsewhere in this codebase. A requester holds the grant until it drops its request or a hold limit expires, so no single client can starve the others. It sits between the client request lines and the shared resource's enable/select inputs.

## Interface
- MAX_HOLD, 8: maximum consecutive cycles one grant may be held; legal range 2..255.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request lines; bit i is requester i; level-sensitive.
- gnt  output  4  one-hot grant (all-zero when idle), decoded from gnt_id.
- gnt_id  output  2  index of current grantee; valid only when gnt_valid=1.
- gnt_valid  output  1  high while any grant is held.
- expired  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

## Operation
- State register with two states: IDLE and GRANT.
- State ptr[1:0] is the highest-priority index. Search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- IDLE, when req != 0:
  - select the first asserted bit in search order;
  - load gnt_id with that index;
  - clear hold_cnt;
  - go to GRANT.
- IDLE, when req == 0: stay in IDLE; ptr is unchanged.
- GRANT: gnt = decode(gnt_id), gnt_valid = 1, and hold_cnt increments each cycle.
- Release path, when req[gnt_id] = 0:
  - go to IDLE;
  - ptr <= gnt_id+1 mod 4, so 3 wraps to 0.
- Timeout path, when req[gnt_id] is still 1 and hold_cnt == MAX_HOLD-1:
  - go to IDLE;
  - pulse expired for one cycle;
  - ptr <= gnt_id+1 mod 4.
- If a drop and a timeout occur in the same cycle, it is treated as a release and expired stays 0.
- Requests on other bits during GRANT are ignored; they are evaluated in the next IDLE cycle.
- hold_cnt width is clog2(MAX_HOLD). Its terminal value is MAX_HOLD-1, so it never wraps.
- Reset values, applied immediately on rst:
  - state = IDLE, ptr = 0, gnt_id = 0, hold_cnt = 0;
  - gnt = 4'b0000, gnt_valid = 0, expired = 0.
- Reset mid-grant drops gnt asynchronously. The first grant after reset uses ptr = 0.

## Timing
- All outputs are registered or decoded directly from registers. There is no combinational path from req to any output.
- Grant latency: req sampled at edge N in IDLE gives gnt valid after edge N+1.
- Release latency: req[gnt_id] low at edge N means gnt is 0 after edge N+1.
- After every release or timeout there is one mandatory IDLE cycle, so back-to-back grants are separated by one gap cycle.
- Maximum grant duration is exactly MAX_HOLD cycles with gnt_valid=1.
- expired is high for exactly the one cycle following the last grant cycle. It coincides with the IDLE cycle.
- Worst-case wait for a continuously requesting client is 3*(MAX_HOLD+1) cycles before its grant.

## Structure
- Shared package arb_pkg holds:
  - the state encoding constants ST_IDLE=1'b0 and ST_GRANT=1'b1;
  - the requester count constant NREQ=4.
- Sub-module onehot_dec2x4 (inputs sel[1:0], en; output y[3:0]) produces gnt from gnt_id, with en=gnt_valid. It is gate-level, with an enable AND on each output.
- The priority search is a pure combinational function inside arb4_rr_ctrl and is not a separate module.

## Test plan
- Reset: assert rst mid-GRANT with gnt=4'b0100 -> gnt=0, gnt_valid=0, expired=0 immediately; after release, req=4'b1111 grants index 0 first.
- Single client: req=4'b0010 at edge 1 -> gnt=4'b0010 and gnt_id=1 after edge 2. Drop req at edge 5 -> gnt=0 after edge 6, with ptr=2.
- Fair rotation: req=4'b1111 held, with each grantee dropping after 2 cycles -> grants appear in order 0,1,2,3,0, each separated by one idle cycle.
- Wrap-around: ptr=3 (last grantee 2) with req=4'b1001 -> grant goes to 3, then 0; ptr ends at 1.
- Timeout (MAX_HOLD=8): req=4'b0001 held forever -> gnt_valid high for exactly 8 cycles, expired pulses once, one idle cycle, then regrant to 0 (only requester).
- Simultaneous drop and timeout at hold_cnt=7 -> release with expired=0; meanwhile changes on non-granted req bits do not disturb gnt.
